// File: rtl/soma8bits_serial.sv
`default_nettype none
// ============================================================================
// Module   : soma8bits_serial
// Brief    : Nibble-serial 8-bit adder sequencer driving a shared 4-bit adder
//            (no carry-in) with a valid/ready handshake on each side.
// Revision : 1.0 - initial release
// ============================================================================
module soma8bits_serial #(
    parameter bit SKIP_INC = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_o,
    input  logic       add_c,
    output logic [7:0] sum,
    output logic       cout,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LO   = 3'd1;
    localparam logic [2:0] c_HI   = 3'd2;
    localparam logic [2:0] c_INC  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_ra;
    logic [7:0] r_rb;
    logic       r_c0;
    logic       r_c1;

    assign in_ready  = (r_state == c_IDLE) && !rst;
    assign out_valid = (r_state == c_DONE);

    // The shared adder is only borrowed in LO, HI and INC; otherwise it sees zeros.
    always_comb begin
        add_a = 4'd0;
        add_b = 4'd0;
        case (r_state)
            c_LO: begin
                add_a = r_ra[3:0];
                add_b = r_rb[3:0];
            end
            c_HI: begin
                add_a = r_ra[7:4];
                add_b = r_rb[7:4];
            end
            c_INC: begin
                add_a = sum[7:4];
                add_b = {3'b000, r_c0};
            end
            default: begin
                add_a = 4'd0;
                add_b = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ra    <= 8'd0;
            r_rb    <= 8'd0;
            r_c0    <= 1'b0;
            r_c1    <= 1'b0;
            sum     <= 8'd0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_state <= c_LO;
                    end
                end
                c_LO: begin
                    sum[3:0] <= add_o;
                    r_c0     <= add_c;
                    r_state  <= c_HI;
                end
                c_HI: begin
                    sum[7:4] <= add_o;
                    r_c1     <= add_c;
                    if (SKIP_INC && !r_c0) begin
                        cout    <= add_c;
                        r_state <= c_DONE;
                    end else begin
                        r_state <= c_INC;
                    end
                end
                c_INC: begin
                    // c1 and the increment carry never coincide, so OR is exact.
                    sum[7:4] <= add_o;
                    cout     <= r_c1 | add_c;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soma8bits_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_soma8bits_serial
// Brief    : Scoreboard bench for soma8bits_serial, one instance per SKIP_INC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soma8bits_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] in_ready;
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [3:0] add_a [2];
    logic [3:0] add_b [2];
    logic [3:0] add_o [2];
    logic [1:0] add_c;
    logic [7:0] sum [2];
    logic [1:0] cout;
    logic [1:0] out_valid;
    logic [1:0] out_ready = 2'b11;
    logic [1:0] rand_mode = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_edge [2];
    logic [1:0] seen = 2'b00;
    logic [8:0] hold [2];

    // Entry: {expected latency[1:0], cout, sum[7:0]}
    logic [10:0] q0 [$];
    logic [10:0] q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign {add_c[g], add_o[g]} = {1'b0, add_a[g]} + {1'b0, add_b[g]};
        soma8bits_serial #(.SKIP_INC(g == 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a[g]),
            .b         (b[g]),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_o     (add_o[g]),
            .add_c     (add_c[g]),
            .sum       (sum[g]),
            .cout      (cout[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
        );
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    // Random back-pressure for instances in sweep mode
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++)
            if (rand_mode[i]) out_ready[i] = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on first out_valid cycle, stability while stalled, value on consume
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (in_valid[i] && in_ready[i]) acc_edge[i] = cyc + 1;
            if (out_valid[i]) begin
                logic [10:0] e;
                chk("in_ready_in_done", i, {31'd0, in_ready[i]}, 32'd0);
                if (qsize(i) == 0) begin
                    chk("unexpected_output", i, {23'd0, cout[i], sum[i]}, 32'hFFFF_FFFF);
                end else begin
                    e = (i == 0) ? q0[0] : q1[0];
                    if (!seen[i]) begin
                        chk("latency", i, cyc - acc_edge[i], {30'd0, e[10:9]});
                        seen[i] = 1'b1;
                        hold[i] = {cout[i], sum[i]};
                    end else begin
                        chk("stable_hold", i, {23'd0, cout[i], sum[i]}, {23'd0, hold[i]});
                    end
                    if (out_ready[i]) begin
                        chk("result", i, {23'd0, cout[i], sum[i]}, {23'd0, e[8:0]});
                        if (i == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                        seen[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input int idx, input logic [7:0] x, input logic [7:0] y);
        logic [8:0]  s;
        logic [4:0]  lo;
        logic [1:0]  lat;
        bit          ok;
        s   = {1'b0, x} + {1'b0, y};
        lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]};
        lat = (idx == 1 && !lo[4]) ? 2'd2 : 2'd3;
        @(posedge clk); #1;
        a[idx] = x;
        b[idx] = y;
        in_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", idx, 32'd0, 32'd1);
        end else if (idx == 0) begin
            q0.push_back({lat, s});
        end else begin
            q1.push_back({lat, s});
        end
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
    endtask

    task automatic drain(input int idx);
        for (int t = 0; t < 5000 && qsize(idx) != 0; t++) @(negedge clk);
        if (qsize(idx) != 0) chk("drain_timeout", idx, qsize(idx), 32'd0);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 2; i++) begin
            a[i] = 8'd0;
            b[i] = 8'd0;
            acc_edge[i] = 0;
            hold[i] = 9'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int idx = 0; idx < 2; idx++) begin
            // Abort an operation in HI with reset; nothing must come out of it
            @(posedge clk); #1;
            a[idx] = 8'h92; b[idx] = 8'h24; in_valid[idx] = 1'b1;
            @(posedge clk); #1 in_valid[idx] = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("rst_in_ready", idx, {31'd0, in_ready[idx]}, 32'd1);
            chk("rst_sum", idx, {24'd0, sum[idx]}, 32'd0);
            chk("rst_cout", idx, {31'd0, cout[idx]}, 32'd0);
            chk("rst_out_valid", idx, {31'd0, out_valid[idx]}, 32'd0);
            chk("rst_add_a", idx, {28'd0, add_a[idx]}, 32'd0);
            chk("rst_add_b", idx, {28'd0, add_b[idx]}, 32'd0);

            send(idx, 8'h92, 8'h24);
            send(idx, 8'hA6, 8'h5B);
            send(idx, 8'hFF, 8'hFF);
            send(idx, 8'h00, 8'h00);
            drain(idx);

            // Back-pressure with ignored operand pulses
            out_ready[idx] = 1'b0;
            send(idx, 8'h31, 8'h4C);
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (out_valid[idx]) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("stall_wait_timeout", idx, 32'd0, 32'd1);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                a[idx] = 8'h55; b[idx] = 8'h55;
                in_valid[idx] = (k % 2 == 0);
            end
            @(posedge clk); #1;
            in_valid[idx] = 1'b0;
            out_ready[idx] = 1'b1;
            send(idx, 8'h10, 8'h20);
            drain(idx);

            rand_mode[idx] = 1'b1;
            for (int n = 0; n < 256; n++)
                send(idx, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            drain(idx);
            rand_mode[idx] = 1'b0;
            @(posedge clk); #1 out_ready[idx] = 1'b1;
            repeat (4) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
